// File: rtl/sd_emmc_ddr_dat_tx.sv
// sd_emmc_ddr_dat_tx: per-DAT-line DDR write framer (start bit, data, dual CRC16, end bit)
// producing the rising/falling edge bit pair for the line's ODDR cell.
module sd_emmc_ddr_dat_tx #(
  parameter int BLOCK_BYTES = 512
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic       Abort,
  input  logic [7:0] DataIn,
  input  logic       DataValid,
  output logic       DataReady,
  output logic       WriteData_posEdge,
  output logic       WriteData_negEdge,
  output logic       OutputEnable,
  output logic       Busy,
  output logic       Done,
  output logic       Underrun
);
  localparam int W = $clog2(BLOCK_BYTES + 1);
  localparam logic [W-1:0] NBYTES = W'(BLOCK_BYTES);
  localparam logic [W-1:0] LAST = W'(BLOCK_BYTES - 1);
  typedef enum logic [2:0] {IDLE, LOAD, STARTBIT, DATA, CRC, ENDBIT} state_t;
  state_t st_q, st_d;
  logic [7:0] sh_q, sh_d, hold_q, hold_d;
  logic full_q, full_d, urun_q, urun_d;
  logic [W-1:0] fetch_q, fetch_d, sent_q, sent_d;
  logic [1:0] k_q, k_d;
  logic [3:0] i_q, i_d;
  logic [15:0] cp_q, cp_d, cn_q, cn_d;
  logic pos_q, pos_d, neg_q, neg_d, oe_q, oe_d, done_q, done_d, und_q, und_d;
  logic hs;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ({16{c[15] ^ b}} & 16'h1021);
  endfunction

  assign Busy = st_q != IDLE;
  assign DataReady = st_q == LOAD || ((st_q == STARTBIT || st_q == DATA) && !full_q && fetch_q < NBYTES);
  assign hs = DataValid && DataReady;
  assign WriteData_posEdge = pos_q;
  assign WriteData_negEdge = neg_q;
  assign OutputEnable = oe_q;
  assign Done = done_q;
  assign Underrun = und_q;

  always_comb begin
    st_d = st_q;
    sh_d = sh_q;
    hold_d = hold_q;
    full_d = full_q;
    urun_d = urun_q;
    fetch_d = hs ? fetch_q + 1'b1 : fetch_q;
    sent_d = sent_q;
    k_d = k_q;
    i_d = i_q;
    cp_d = cp_q;
    cn_d = cn_q;
    done_d = 1'b0;
    und_d = 1'b0;
    if (hs && st_q != LOAD) begin
      hold_d = DataIn;
      full_d = 1'b1;
    end
    case (st_q)
      IDLE: st_d = Start ? LOAD : IDLE;
      LOAD: if (hs) begin
        sh_d = DataIn;
        st_d = STARTBIT;
      end
      STARTBIT: st_d = DATA;
      DATA: begin
        cp_d = crc_step(cp_q, sh_q[7]);
        cn_d = crc_step(cn_q, sh_q[6]);
        sh_d = {sh_q[5:0], 2'b00};
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          sent_d = sent_q + 1'b1;
          if (sent_q == LAST) st_d = CRC;
          else if (full_q) begin
            sh_d = hold_q;
            full_d = 1'b0;
          end else begin
            st_d = ENDBIT;
            urun_d = 1'b1;
          end
        end
      end
      CRC: begin
        cp_d = {cp_q[14:0], 1'b0};
        cn_d = {cn_q[14:0], 1'b0};
        i_d = i_q + 4'd1;
        if (i_q == 4'd15) st_d = ENDBIT;
      end
      ENDBIT: begin
        st_d = IDLE;
        done_d = 1'b1;
        und_d = urun_q;
      end
      default: st_d = IDLE;
    endcase
    if (Abort && st_q != IDLE) begin
      st_d = IDLE;
      done_d = 1'b0;
      und_d = 1'b0;
    end
    // Every return to IDLE (end of block or abort) wipes the datapath for the next block.
    if (st_d == IDLE) begin
      sh_d = '0;
      hold_d = '0;
      full_d = 1'b0;
      urun_d = 1'b0;
      fetch_d = '0;
      sent_d = '0;
      k_d = '0;
      i_d = '0;
      cp_d = '0;
      cn_d = '0;
    end
    pos_d = st_d == DATA ? sh_d[7] : st_d == CRC ? cp_d[15] : st_d != STARTBIT;
    neg_d = st_d == DATA ? sh_d[6] : st_d == CRC ? cn_d[15] : st_d != STARTBIT;
    oe_d = !(st_d == IDLE || st_d == LOAD);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      st_q <= IDLE;
      sh_q <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
      urun_q <= 1'b0;
      fetch_q <= '0;
      sent_q <= '0;
      k_q <= '0;
      i_q <= '0;
      cp_q <= '0;
      cn_q <= '0;
      pos_q <= 1'b1;
      neg_q <= 1'b1;
      oe_q <= 1'b0;
      done_q <= 1'b0;
      und_q <= 1'b0;
    end else begin
      st_q <= st_d;
      sh_q <= sh_d;
      hold_q <= hold_d;
      full_q <= full_d;
      urun_q <= urun_d;
      fetch_q <= fetch_d;
      sent_q <= sent_d;
      k_q <= k_d;
      i_q <= i_d;
      cp_q <= cp_d;
      cn_q <= cn_d;
      pos_q <= pos_d;
      neg_q <= neg_d;
      oe_q <= oe_d;
      done_q <= done_d;
      und_q <= und_d;
    end
  end
endmodule

// File: tb/tb_sd_emmc_ddr_dat_tx.sv
// tb_sd_emmc_ddr_dat_tx: scoreboard bench for the DDR DAT framer; one 4-byte and one 512-byte instance
// share the stimulus, sel picks which one a scenario drives and observes.
module tb_sd_emmc_ddr_dat_tx;
  logic Clk = 1'b0, Reset = 1'b0, Start = 1'b0, Abort = 1'b0, DataValid = 1'b0, sel = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic rdy4, pos4, neg4, oe4, busy4, done4, und4;
  logic rdy5, pos5, neg5, oe5, busy5, done5, und5;
  logic rdy, pos, neg, oe, busy, done, und;
  int checks = 0, failures = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];
  int oe_cnt, oe_runs;
  logic done_seen, und_seen, busy_at_done, timed_out;
  logic [4:0] snap;
  logic [7:0] blk[512];

  always #5 Clk = ~Clk;

  sd_emmc_ddr_dat_tx #(.BLOCK_BYTES(4)) u4 (
    .Clk(Clk), .Reset(Reset), .Start(Start && !sel), .Abort(Abort), .DataIn(DataIn),
    .DataValid(DataValid), .DataReady(rdy4), .WriteData_posEdge(pos4), .WriteData_negEdge(neg4),
    .OutputEnable(oe4), .Busy(busy4), .Done(done4), .Underrun(und4));

  sd_emmc_ddr_dat_tx #(.BLOCK_BYTES(512)) u512 (
    .Clk(Clk), .Reset(Reset), .Start(Start && sel), .Abort(Abort), .DataIn(DataIn),
    .DataValid(DataValid), .DataReady(rdy5), .WriteData_posEdge(pos5), .WriteData_negEdge(neg5),
    .OutputEnable(oe5), .Busy(busy5), .Done(done5), .Underrun(und5));

  assign rdy = sel ? rdy5 : rdy4;
  assign pos = sel ? pos5 : pos4;
  assign neg = sel ? neg5 : neg4;
  assign oe = sel ? oe5 : oe4;
  assign busy = sel ? busy5 : busy4;
  assign done = sel ? done5 : done4;
  assign und = sel ? und5 : und4;

  // Reference CRC as polynomial long division of the augmented message (init 0).
  function automatic logic [15:0] crc_model(input logic bits[$]);
    logic [16:0] r;
    r = '0;
    for (int j = 0; j < bits.size() + 16; j++) begin
      r = {r[15:0], (j < bits.size()) ? bits[j] : 1'b0};
      if (r[16]) r = r ^ 17'h11021;
    end
    return r[15:0];
  endfunction

  // Drives one block from blk[], pushing expected edge pairs on each handshake and popping them as OE cycles appear.
  // ev_kind 1 pulses Abort, 2 pulls Reset, in OE cycle ev_at; snap then holds {oe,pos,neg,rdy,busy}.
  task automatic run_block(input int nbytes, input int navail, input int max_gap, input bit urun,
                           input int ev_at, input int ev_kind);
    int idx, gap, post;
    logic prev_oe, bad;
    logic [1:0] e;
    logic pb[$];
    logic nq[$];
    logic [15:0] cp, cn;
    logic [7:0] b;
    exp_q.delete(); obs_q.delete();
    oe_cnt = 0; oe_runs = 0; done_seen = 0; und_seen = 0; busy_at_done = 1; timed_out = 1; snap = '0;
    idx = 0; gap = 0; post = -1; prev_oe = 0; bad = 0;
    Start = 1; DataValid = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge Clk);
      Start = 0;
      if (oe) begin
        obs_q.push_back({pos, neg});
        oe_cnt++;
        if (!prev_oe) oe_runs++;
        if (!bad) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++; bad = 1;
            $display("FAIL stream[%0d]: got pos/neg=%b, expected no OE cycle", oe_cnt - 1, {pos, neg});
          end else begin
            e = exp_q.pop_front();
            if ({pos, neg} !== e) begin
              failures++; bad = 1;
              $display("FAIL stream[%0d]: got pos/neg=%b, expected %b", oe_cnt - 1, {pos, neg}, e);
            end
          end
        end
      end
      prev_oe = oe;
      if (done) begin
        done_seen = 1; und_seen = und; busy_at_done = busy;
      end
      if (post > 0) begin
        post--;
        if (post == 0) begin timed_out = 0; DataValid = 0; break; end
        continue;
      end
      if (done_seen && ev_kind == 0) begin timed_out = 0; DataValid = 0; break; end
      if (ev_kind != 0 && post < 0 && oe && oe_cnt == ev_at + 1) begin
        DataValid = 0; idx = navail;
        if (ev_kind == 1) begin
          Abort = 1;
          @(negedge Clk);
          Abort = 0;
          snap = {oe, pos, neg, rdy, busy};
        end else begin
          Reset = 0;
          #1 snap = {oe, pos, neg, rdy, busy};
          @(negedge Clk);
          Reset = 1;
        end
        post = 12;
        continue;
      end
      if (gap > 0) begin DataValid = 0; gap--; end
      else if (idx < navail) begin DataValid = 1; DataIn = blk[idx]; end
      else DataValid = 0;
      if (DataValid && rdy) begin
        if (idx == 0) exp_q.push_back(2'b00);
        b = DataIn;
        for (int j = 3; j >= 0; j--) begin
          exp_q.push_back({b[2*j+1], b[2*j]});
          pb.push_back(b[2*j+1]);
          nq.push_back(b[2*j]);
        end
        idx++;
        gap = max_gap > 0 ? int'($urandom_range(max_gap, 0)) : 0;
        if (idx == nbytes) begin
          cp = crc_model(pb);
          cn = crc_model(nq);
          for (int j = 15; j >= 0; j--) exp_q.push_back({cp[j], cn[j]});
          exp_q.push_back(2'b11);
        end else if (urun && idx == navail) exp_q.push_back(2'b11);
      end
    end
  endtask

  task automatic test_reset();
    Reset = 0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({oe4, pos4, neg4, rdy4, busy4, done4, und4} !== 7'b0110000) begin
      failures++;
      $display("FAIL reset_u4: got oe,pos,neg,rdy,busy,done,und=%b, expected 0110000",
               {oe4, pos4, neg4, rdy4, busy4, done4, und4});
    end
    checks++;
    if ({oe5, pos5, neg5, rdy5, busy5, done5, und5} !== 7'b0110000) begin
      failures++;
      $display("FAIL reset_u512: got oe,pos,neg,rdy,busy,done,und=%b, expected 0110000",
               {oe5, pos5, neg5, rdy5, busy5, done5, und5});
    end
    Reset = 1;
    @(negedge Clk);
  endtask

  task automatic test_zeros();
    sel = 0;
    for (int j = 0; j < 4; j++) blk[j] = 8'h00;
    run_block(4, 4, 0, 0, 0, 0);
    checks++;
    if (timed_out !== 1'b0) begin failures++; $display("FAIL zeros_timeout: got no Done, expected Done"); end
    checks++;
    if (oe_cnt !== 34 || oe_runs !== 1) begin
      failures++; $display("FAIL zeros_oe: got %0d OE cycles in %0d runs, expected 34 in 1", oe_cnt, oe_runs);
    end
    checks++;
    if ({done_seen, und_seen, busy_at_done} !== 3'b100) begin
      failures++; $display("FAIL zeros_done: got done,und,busy=%b, expected 100", {done_seen, und_seen, busy_at_done});
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL zeros_left: got %0d unsent pairs, expected 0", exp_q.size()); end
    @(negedge Clk);
    checks++;
    if ({done, busy} !== 2'b00) begin failures++; $display("FAIL done_width: got done,busy=%b, expected 00", {done, busy}); end
  endtask

  task automatic test_aa();
    logic ones[$];
    logic [15:0] want_p, got_p, got_n;
    for (int j = 0; j < 16; j++) ones.push_back(1'b1);
    want_p = crc_model(ones);
    sel = 0;
    for (int j = 0; j < 4; j++) blk[j] = 8'hAA;
    run_block(4, 4, 0, 0, 0, 0);
    checks++;
    if (obs_q.size() !== 34 || done_seen !== 1'b1) begin
      failures++; $display("FAIL aa_len: got %0d OE cycles done=%b, expected 34 done=1", obs_q.size(), done_seen);
    end else begin
      for (int j = 0; j < 16; j++) begin
        got_p[15-j] = obs_q[17+j][1];
        got_n[15-j] = obs_q[17+j][0];
      end
      checks++;
      if (got_p !== want_p) begin failures++; $display("FAIL aa_crc_p: got %h, expected %h", got_p, want_p); end
      checks++;
      if (got_n !== 16'h0000) begin failures++; $display("FAIL aa_crc_n: got %h, expected 0000", got_n); end
    end
  endtask

  task automatic test_underrun();
    sel = 0;
    blk[0] = 8'hC3; blk[1] = 8'h96; blk[2] = 8'h11; blk[3] = 8'h22;
    run_block(4, 2, 0, 1, 0, 0);
    checks++;
    if (timed_out !== 1'b0 || oe_cnt !== 10 || oe_runs !== 1) begin
      failures++; $display("FAIL underrun_oe: got %0d OE cycles timeout=%b, expected 10 and 0", oe_cnt, timed_out);
    end
    checks++;
    if ({done_seen, und_seen} !== 2'b11) begin
      failures++; $display("FAIL underrun_flag: got done,und=%b, expected 11", {done_seen, und_seen});
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL underrun_left: got %0d unsent pairs, expected 0", exp_q.size()); end
  endtask

  task automatic test_abort();
    sel = 0;
    blk[0] = 8'h3C; blk[1] = 8'h5A; blk[2] = 8'hF0; blk[3] = 8'h81;
    run_block(4, 4, 0, 0, 22, 1);
    checks++;
    if (snap !== 5'b01100) begin failures++; $display("FAIL abort_idle: got oe,pos,neg,rdy,busy=%b, expected 01100", snap); end
    checks++;
    if (done_seen !== 1'b0 || oe_cnt !== 23) begin
      failures++; $display("FAIL abort_done: got done=%b after %0d OE cycles, expected 0 after 23", done_seen, oe_cnt);
    end
    checks++;
    if (exp_q.size() !== 11) begin failures++; $display("FAIL abort_left: got %0d unsent pairs, expected 11", exp_q.size()); end
    run_block(4, 4, 1, 0, 0, 0);
    checks++;
    if ({timed_out, done_seen, und_seen, exp_q.size() == 0} !== 4'b0101) begin
      failures++; $display("FAIL abort_next: got timeout,done,und,empty=%b, expected 0101",
                           {timed_out, done_seen, und_seen, exp_q.size() == 0});
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    blk[0] = 8'hE7; blk[1] = 8'h18; blk[2] = 8'h42; blk[3] = 8'hBD;
    run_block(4, 4, 0, 0, 6, 2);
    checks++;
    if (snap !== 5'b01100) begin failures++; $display("FAIL reset_mid: got oe,pos,neg,rdy,busy=%b, expected 01100", snap); end
    checks++;
    if (done_seen !== 1'b0) begin failures++; $display("FAIL reset_mid_done: got done=1, expected 0"); end
    run_block(4, 4, 2, 0, 0, 0);
    checks++;
    if ({timed_out, done_seen, und_seen, oe_cnt == 34, exp_q.size() == 0} !== 5'b01011) begin
      failures++; $display("FAIL reset_next: got timeout,done,und,oe34,empty=%b, expected 01011",
                           {timed_out, done_seen, und_seen, oe_cnt == 34, exp_q.size() == 0});
    end
  endtask

  task automatic test_long();
    sel = 1;
    for (int j = 0; j < 512; j++) blk[j] = 8'(j);
    run_block(512, 512, 3, 0, 0, 0);
    checks++;
    if (oe_cnt !== 2066 || oe_runs !== 1) begin
      failures++; $display("FAIL long_oe: got %0d OE cycles in %0d runs, expected 2066 in 1", oe_cnt, oe_runs);
    end
    checks++;
    if ({timed_out, done_seen, und_seen, exp_q.size() == 0} !== 4'b0101) begin
      failures++; $display("FAIL long_done: got timeout,done,und,empty=%b, expected 0101",
                           {timed_out, done_seen, und_seen, exp_q.size() == 0});
    end
    sel = 0;
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_aa();
    test_underrun();
    test_abort();
    test_reset_mid();
    test_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sd_emmc_ddr_dat_tx.md
# sd_emmc_ddr_dat_tx

DDR write-data transmitter for one eMMC DAT line. Accepts block bytes over a valid/ready stream and produces the per-edge bit pair consumed by the line's DDR I/O cell. That cell's ODDR drives WriteData_posEdge on the rising edge and WriteData_negEdge on the falling edge. Frames each block as start bit, data, two interleaved CRC16s (rising-edge bits and falling-edge bits), and end bit, per eMMC DDR data timing. One instance per DAT line in the host controller write path.

## Interface
- BLOCK_BYTES, 512: bytes per block on this line; legal range ≥1, ≤4096.
- Clk  in  1  bus clock; same clock as the DDR I/O cell.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle request to send one block; sampled only in IDLE.
- Abort  in  1  synchronous abort; any non-IDLE state goes to IDLE next cycle.
- DataIn  in  8  block byte.
- DataValid  in  1  DataIn valid.
- DataReady  out  1  byte accepted when DataValid && DataReady.
- WriteData_posEdge  out  1  bit for the rising edge; registered.
- WriteData_negEdge  out  1  bit for the falling edge; registered.
- OutputEnable  out  1  line drive enable; registered.
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle pulse when the block ends (normal or underrun).
- Underrun  out  1  valid with Done; 1 means the block was truncated.

## Operation
- States: IDLE, LOAD, STARTBIT, DATA, CRC, ENDBIT.
- IDLE: OutputEnable=0, both data outputs=1. Start → LOAD.
- LOAD: DataReady=1, OutputEnable=0. The first accepted byte goes into the 8-bit shift register → STARTBIT.
- STARTBIT: 1 cycle; pos=0, neg=0, OE=1 → DATA.
- DATA: 4 cycles per byte, MSB first. Cycle k of the byte (k=0..3) drives pos=bit[7-2k] and neg=bit[6-2k].
- DATA holding register: one-byte register behind the shifter. DataReady = holding register empty && bytes fetched < BLOCK_BYTES && state ∈ {STARTBIT, DATA}.
- Byte boundary: on cycle k=3, the shifter reloads from the holding register. When all BLOCK_BYTES are sent → CRC.
- Underrun: if, on cycle k=3, bytes remain and the holding register is empty → ENDBIT with Underrun latched; CRC is skipped.
- CRC accumulation: two CRC16-CCITT engines (x^16+x^12+x^5+1, init 0x0000). crc_p shifts each pos bit; crc_n shifts each neg bit. Only DATA bits are covered.
- CRC: 16 cycles; pos=crc_p[15-i], neg=crc_n[15-i] for i=0..15 → ENDBIT.
- ENDBIT: 1 cycle; pos=1, neg=1, OE=1 → IDLE, asserting Done (and Underrun if latched) in the first IDLE cycle.
- Abort: → IDLE; OE=0 and outputs=1 next cycle. Holding register, shifter, CRCs and counters are cleared. No Done.
- Start outside IDLE is ignored. DataValid outside LOAD/STARTBIT/DATA is ignored.

## Timing
- Reset values: OutputEnable=0, WriteData_posEdge=1, WriteData_negEdge=1, DataReady=0, Busy=0, Done=0, Underrun=0. All counters, CRCs and the holding register are cleared. Reset may assert mid-block; the line is released immediately (asynchronous).
- Bus occupancy is 1 + 4·BLOCK_BYTES + 16 + 1 cycles of OE=1, contiguous when no underrun occurs.
- STARTBIT is driven the cycle after the first byte handshake in LOAD.
- Outputs change only on Clk rising edges. The ODDR adds its own fixed output register stage, which is outside this block.
- A source presenting DataValid continuously never underruns. Minimum sustained rate is 1 byte per 4 cycles.
- Done and Underrun are high for exactly 1 cycle. Busy falls in the same cycle Done rises.
- Start may be reasserted in the Done cycle. The next LOAD follows 1 cycle later.

## Test plan
- BLOCK_BYTES=4, all bytes 0x00, DataValid always high → STARTBIT (0,0); 16 DATA cycles (0,0); 16 CRC cycles (0,0) since both CRCs are 0x0000; ENDBIT (1,1); OE high for 34 cycles; Done=1, Underrun=0.
- BLOCK_BYTES=512, bytes 0x00..0xFF repeating, random DataValid gaps ≤3 cycles → per-edge bit sequence and crc_p/crc_n match the reference model. OE high for 2066 contiguous cycles.
- BLOCK_BYTES=4, byte 0xAA ×4 → neg stream all 0 with crc_n=0x0000; pos stream all 1 with crc_p equal to the model's CRC of 16 ones.
- BLOCK_BYTES=4, DataValid dropped after the 2nd byte → after 8 DATA cycles, ENDBIT (1,1) with no CRC phase; Done=1, Underrun=1.
- Abort asserted in CRC cycle 5 → next cycle IDLE, OE=0, outputs (1,1), Done never pulses; a following Start sends a complete block with correct CRCs.
- Reset pulled low during DATA → OE=0, DataReady=0, Busy=0 asynchronously; after release, Start produces a correct block.
